// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants and state encoding for the nibble-serial subtractor.
// The slice width is fixed at one nibble.
package nibble_serial_subtractor_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A single-nibble build still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_nibble_slice.sv
// Combinational 4-bit ripple-borrow subtractor slice: d = a - b - bi.
// bo is the borrow out of the top bit.
module sub_nibble_slice
    import nibble_serial_subtractor_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                bi,
    output logic [NIBBLE_W-1:0] d,
    output logic                bo
);

    logic [NIBBLE_W:0] chain;

    always_comb begin
        chain    = '0;
        d        = '0;
        chain[0] = bi;
        for (int i = 0; i < NIBBLE_W; i++) begin
            d[i]       = a[i] ^ b[i] ^ chain[i];
            chain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
        end
        bo = chain[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Wide subtractor that runs one nibble slice over WIDTH/4 cycles.
// It uses valid/ready handshakes on the operand side and on the result side.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic [WIDTH-1:0]          diff_r;
    logic                      brw;
    logic                      bout_r;
    logic [CNT_W-1:0]          cnt;
    logic [NIBBLE_W-1:0]       sl_d;
    logic                      sl_bo;
    logic [WIDTH+NIBBLE_W-1:0] diff_cat;

    sub_nibble_slice u_slice (
        .a  (a_sh[NIBBLE_W-1:0]),
        .b  (b_sh[NIBBLE_W-1:0]),
        .bi (brw),
        .d  (sl_d),
        .bo (sl_bo)
    );

    // New nibble enters at the top; the low nibble falls off the bottom.
    always_comb begin
        diff_cat = {sl_d, diff_r};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE:  in_ready = 1'b1;
            S_RUN:   busy = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_r <= '0;
            brw    <= 1'b0;
            bout_r <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh <= a;
                        b_sh <= b;
                        brw  <= bin;
                        cnt  <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> NIBBLE_W;
                    b_sh   <= b_sh >> NIBBLE_W;
                    diff_r <= diff_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
                    brw    <= sl_bo;
                    // Counter parks on the last nibble instead of wrapping.
                    if (cnt == CNT_LAST) begin
                        bout_r <= sl_bo;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor at WIDTH=16 and WIDTH=4.
// Results are compared with plain-arithmetic subtraction.
module tb_nibble_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, bin, out_valid, out_ready, bout, busy;
    logic [15:0] a, b, diff;
    logic        in_valid4, in_ready4, bin4, out_valid4, out_ready4, bout4, busy4;
    logic [3:0]  a4, b4, diff4;

    int checks = 0;
    int errors = 0;

    nibble_serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .busy(busy)
    );

    nibble_serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .bout(bout4), .busy(busy4)
    );

    function automatic longint ref_diff(input int w, input longint ra, input longint rb,
                                        input longint rbin);
        longint d;
        d = ra - rb - rbin;
        return d & ((longint'(1) << w) - 1);
    endfunction

    function automatic bit ref_bout(input longint ra, input longint rb, input longint rbin);
        return ra < rb + rbin;
    endfunction

    task automatic send16(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                          output int lat, output bit busy_all);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
        lat = 0;
        busy_all = 1'b1;
        while (!out_valid && lat < 50) begin
            if (!busy) busy_all = 1'b0;
            @(posedge clk); #1; lat++;
        end
        if (!busy) busy_all = 1'b0;
    endtask

    task automatic send4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                         output int lat);
        int guard = 0;
        while (!in_ready4 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        a4 = ta; b4 = tb; bin4 = tbin; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 0;
        while (!out_valid4 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic handoff16();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic handoff4();
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; a = 0; b = 0; bin = 0; out_ready = 0;
        in_valid4 = 0; a4 = 0; b4 = 0; bin4 = 0; out_ready4 = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({in_ready, out_valid, busy, bout, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            errors++; $display("FAIL reset16 got rdy/vld/busy/bout/diff=%b%b%b%b/%h exp=1000/0000",
                               in_ready, out_valid, busy, bout, diff);
        end
        checks++; if ({in_ready4, out_valid4, busy4, bout4, diff4} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            errors++; $display("FAIL reset4 got %b%b%b%b/%h exp=1000/0", in_ready4, out_valid4,
                               busy4, bout4, diff4);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; bit bz;
        send16(16'h1234, 16'h0234, 1'b0, lat, bz);
        checks++; if (lat !== 4) begin errors++; $display("FAIL t1_latency got=%0d exp=4", lat); end
        checks++; if (bz !== 1'b1) begin errors++; $display("FAIL t1_busy got=%b exp=1", bz); end
        checks++; if (diff !== 16'h1000 || bout !== 1'b0) begin
            errors++; $display("FAIL t1_result got=%h/%b exp=1000/0", diff, bout);
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t1_in_ready_done got=%b exp=0", in_ready); end
        handoff16();
        checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++; $display("FAIL t1_after_handoff got=%b%b%b exp=100", in_ready, out_valid, busy);
        end
        checks++; if (diff !== 16'h1000) begin errors++; $display("FAIL t1_diff_kept got=%h exp=1000", diff); end
    endtask

    task automatic test_borrow_edges();
        int lat; bit bz;
        send16(16'h0000, 16'h0001, 1'b0, lat, bz);
        checks++; if (diff !== 16'hFFFF || bout !== 1'b1) begin
            errors++; $display("FAIL t2_underflow got=%h/%b exp=ffff/1", diff, bout);
        end
        handoff16();
        send16(16'h8000, 16'h7FFF, 1'b1, lat, bz);
        checks++; if (diff !== 16'h0000 || bout !== 1'b0) begin
            errors++; $display("FAIL t2_bin got=%h/%b exp=0000/0", diff, bout);
        end
        handoff16();
    endtask

    task automatic test_backpressure();
        int lat; bit bz; bit stable;
        logic [15:0] d0; logic b0;
        send16(16'hBEEF, 16'h1F2E, 1'b1, lat, bz);
        d0 = diff; b0 = bout;
        checks++; if (d0 !== 16'(ref_diff(16, 16'hBEEF, 16'h1F2E, 1)) || b0 !== 1'b0) begin
            errors++; $display("FAIL t3_result got=%h/%b exp=9fc0/0", d0, b0);
        end
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            if (!out_valid || in_ready || diff !== d0 || bout !== b0) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL t3_hold got=%b exp=1", stable); end
        in_valid = 1'b1;
        handoff16();
        checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++; $display("FAIL t3_release got=%b%b%b exp=100", in_ready, out_valid, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat; bit bz; bit no_vld;
        a = 16'hABCD; b = 16'h1234; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, out_valid, busy, bout, diff} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            errors++; $display("FAIL t4_async_reset got %b%b%b%b/%h exp=1000/0000",
                               in_ready, out_valid, busy, bout, diff);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        no_vld = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid || busy) no_vld = 1'b0;
        end
        checks++; if (no_vld !== 1'b1) begin errors++; $display("FAIL t4_no_pulse got=%b exp=1", no_vld); end
        send16(16'h00FF, 16'h0001, 1'b0, lat, bz);
        checks++; if (diff !== 16'h00FE || bout !== 1'b0 || lat !== 4) begin
            errors++; $display("FAIL t4_next_op got=%h/%b lat=%0d exp=00fe/0 lat=4", diff, bout, lat);
        end
        handoff16();
    endtask

    task automatic test_width4();
        int lat;
        send4(4'h3, 4'h5, 1'b0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL t5_latency got=%0d exp=1", lat); end
        checks++; if (diff4 !== 4'hE || bout4 !== 1'b1) begin
            errors++; $display("FAIL t5_result got=%h/%b exp=e/1", diff4, bout4);
        end
        handoff4();
        checks++; if ({in_ready4, out_valid4} !== 2'b10) begin
            errors++; $display("FAIL t5_handoff got=%b%b exp=10", in_ready4, out_valid4);
        end
    endtask

    task automatic test_random16(input int n);
        logic [16:0] sb[$];
        logic [16:0] exp;
        logic [15:0] ra, rb; logic rbin;
        int lat; bit bz; bit stable; int errs_before;
        errs_before = errors;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(3)) begin
                a = 16'($urandom); b = 16'($urandom); @(posedge clk); #1;
            end
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
            if (k % 16 == 0) rb = ra;
            sb.push_back({ref_bout(ra, rb, rbin), 16'(ref_diff(16, ra, rb, rbin))});
            send16(ra, rb, rbin, lat, bz);
            stable = (lat == 4) && bz;
            exp = sb.pop_front();
            repeat ($urandom_range(3)) begin
                in_valid = 1'($urandom); a = 16'($urandom);
                @(posedge clk); #1;
                if (!out_valid || {bout, diff} !== exp) stable = 1'b0;
            end
            checks++; if ({bout, diff} !== exp || !stable) begin
                errors++;
                if (errors - errs_before < 10)
                    $display("FAIL rand16 op=%0d a=%h b=%h bin=%b got=%b/%h exp=%b/%h lat=%0d",
                             k, ra, rb, rbin, bout, diff, exp[16], exp[15:0], lat);
            end
            handoff16();
            in_valid = 1'b0;
        end
    endtask

    task automatic test_random4(input int n);
        logic [3:0] ra, rb; logic rbin; int lat; int errs_before;
        errs_before = errors;
        for (int k = 0; k < n; k++) begin
            ra = 4'($urandom); rb = 4'($urandom); rbin = 1'($urandom);
            send4(ra, rb, rbin, lat);
            checks++;
            if (diff4 !== 4'(ref_diff(4, ra, rb, rbin)) || bout4 !== ref_bout(ra, rb, rbin) || lat != 1) begin
                errors++;
                if (errors - errs_before < 10)
                    $display("FAIL rand4 a=%h b=%h bin=%b got=%h/%b lat=%0d", ra, rb, rbin, diff4, bout4, lat);
            end
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
            handoff4();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_edges();
        test_backpressure();
        test_reset_mid_run();
        test_width4();
        test_random16(2500);
        test_random4(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
